adc_capture_buffer: RTL

//  Consumer end of the ADC sample/trigger path. It records a triggered window of 8-bit ADC samples into a circular RAM.
//  The window holds PRE_TRIG samples before the trigger edge and DEPTH-PRE_TRIG samples from the edge onward.
//  It then streams the window out in time order on a valid/ready read port to the SPI/WiFi readout logic.

---
 rtl/adc_cap_pkg.sv | 19 +
 rtl/capture_ram.sv | 36 +++
 rtl/adc_capture_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_cap_pkg.sv
// Shared types and default sizes for the ADC capture buffer.
// Contents:
//   cap_state_t                               capture FSM state encoding
//   DEF_DATA_W / DEF_DEPTH / DEF_PRE_TRIG     default parameter values
package adc_cap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_FILL = 3'd1,
        ARMED    = 3'd2,
        POST     = 3'd3,
        READOUT  = 3'd4
    } cap_state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 1024;
    localparam int DEF_PRE_TRIG = 256;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM. It has one write port and one read port with
// a 1-cycle registered read, and no reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates on the next edge
//   rd_addr  in   read address
//   rd_data  out  registered read data
module capture_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered capture of ADC samples into a circular RAM, followed by an
// in-order valid/ready readout of the window.
// The window holds PRE_TRIG samples before the trigger edge and
// DEPTH-PRE_TRIG samples from the edge onward.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   sample, sample_valid         ADC sample stream
//   trigger                      comparator level (rising edge starts the post window)
//   arm, abort                   start / cancel pulses
//   busy                         high outside IDLE
//   rd_data, rd_valid, rd_ready  readout stream
//   rd_last                      marks the final word
//   done                         1-cycle pulse after the last word is accepted
//
// state    | meaning
// IDLE     | waiting for arm
// PRE_FILL | writing the first PRE_TRIG samples, edges ignored
// ARMED    | writing circularly, waiting for a trigger rising edge
// POST     | writing the remainder of the window after the edge
// READOUT  | streaming DEPTH words, oldest first
module adc_capture_buffer
    import adc_cap_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PRE_TRIG = DEF_PRE_TRIG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    input  logic              trigger,
    input  logic              arm,
    input  logic              abort,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              done
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int POST_N = DEPTH - PRE_TRIG;

    cap_state_t        state;
    logic [AW-1:0]     wr_ptr, trig_addr, rd_addr;
    logic [CW-1:0]     pre_cnt, post_cnt, rd_cnt;
    logic              trig_prev, trig_edge;
    logic              ram_we, ram_re, ram_v, ram_last;
    logic [DATA_W-1:0] ram_q;
    logic              skid_v, skid_last;
    logic [DATA_W-1:0] skid_data;
    logic              pop;
    logic [1:0]        occ;

    always_comb begin
        trig_edge = sample_valid & trigger & ~trig_prev;
        ram_we    = sample_valid & ((state == PRE_FILL) || (state == ARMED) || (state == POST));
        pop       = rd_valid & rd_ready;
        // Words held or in flight after this cycle's pop. A read is issued only
        // when it is sure to fit in the output register plus skid entry.
        occ       = {1'b0, rd_valid} + {1'b0, skid_v} + {1'b0, ram_v} - {1'b0, pop};
        ram_re    = (state == READOUT) && (rd_cnt != '0) && (occ < 2'd2);
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (sample),
        .rd_en   (ram_re),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_ptr    <= '0;
            trig_addr <= '0;
            rd_addr   <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
            trig_prev <= 1'b0;
            ram_v     <= 1'b0;
            ram_last  <= 1'b0;
            skid_v    <= 1'b0;
            skid_last <= 1'b0;
            skid_data <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else begin
            done <= 1'b0;
            if (sample_valid) begin
                trig_prev <= trigger;
            end
            if (abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
                skid_v   <= 1'b0;
                ram_v    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state   <= PRE_FILL;
                            busy    <= 1'b1;
                            wr_ptr  <= '0;
                            pre_cnt <= '0;
                        end
                    end
                    PRE_FILL: begin
                        if (sample_valid) begin
                            wr_ptr  <= wr_ptr + AW'(1);
                            pre_cnt <= pre_cnt + CW'(1);
                            if (pre_cnt == CW'(PRE_TRIG - 1)) begin
                                state <= ARMED;
                            end
                        end
                    end
                    ARMED: begin
                        if (sample_valid) begin
                            wr_ptr <= wr_ptr + AW'(1);
                            if (trig_edge) begin
                                trig_addr <= wr_ptr;
                                post_cnt  <= CW'(POST_N - 1);
                                // The edge sample alone can complete the window.
                                if (POST_N == 1) begin
                                    state   <= READOUT;
                                    rd_addr <= wr_ptr - AW'(PRE_TRIG);
                                    rd_cnt  <= CW'(DEPTH);
                                end else begin
                                    state <= POST;
                                end
                            end
                        end
                    end
                    POST: begin
                        if (sample_valid) begin
                            wr_ptr   <= wr_ptr + AW'(1);
                            post_cnt <= post_cnt - CW'(1);
                            if (post_cnt == CW'(1)) begin
                                state   <= READOUT;
                                rd_addr <= trig_addr - AW'(PRE_TRIG);
                                rd_cnt  <= CW'(DEPTH);
                            end
                        end
                    end
                    READOUT: begin
                        if (ram_re) begin
                            rd_addr <= rd_addr + AW'(1);
                            rd_cnt  <= rd_cnt - CW'(1);
                        end
                        ram_v    <= ram_re;
                        ram_last <= ram_re && (rd_cnt == CW'(1));
                        // Queue order is output register, skid entry, RAM output.
                        if (!rd_valid || pop) begin
                            if (skid_v) begin
                                rd_valid  <= 1'b1;
                                rd_data   <= skid_data;
                                rd_last   <= skid_last;
                                skid_v    <= ram_v;
                                skid_data <= ram_q;
                                skid_last <= ram_last;
                            end else begin
                                rd_valid <= ram_v;
                                if (ram_v) begin
                                    rd_data <= ram_q;
                                    rd_last <= ram_last;
                                end else begin
                                    rd_last <= 1'b0;
                                end
                            end
                        end else if (ram_v) begin
                            skid_v    <= 1'b1;
                            skid_data <= ram_q;
                            skid_last <= ram_last;
                        end
                        if (pop && rd_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
